// File: rtl/y86_fetch_queue.sv
// Prefetching Y86-64 fetch unit: aligned FETCH_BYTES-wide reads fill a byte FIFO,
// and the head instruction is decoded combinationally and handed out by valid/ready.
module y86_fetch_queue #(
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned BUF_DEPTH   = 16,
  parameter int unsigned MEM_BYTES   = 2048,
  parameter logic [63:0] RESET_PC    = 64'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [63:0]              mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [8*FETCH_BYTES-1:0] mem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [63:0]              out_valP,
  output logic [63:0]              out_valC,
  output logic [63:0]              out_pred_pc,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic                     out_instr_valid,
  output logic                     out_imem_error
);
  localparam int unsigned PW  = $clog2(BUF_DEPTH);
  localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned SW  = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
  localparam logic [63:0] OFS_MASK   = 64'(FETCH_BYTES) - 64'd1;
  localparam logic [63:0] ALIGN_MASK = ~OFS_MASK;

  logic [7:0]    buf_q [BUF_DEPTH];
  logic [7:0]    buf_d [BUF_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   head_pc_q, head_pc_d, fetch_addr_q, fetch_addr_d;
  logic [SW-1:0] skip_q, skip_d;
  logic          inflight_q, inflight_d;
  logic          stopped_q, stopped_d;
  logic          err_pending_q, err_pending_d;

  logic [7:0]  b [10];
  logic [3:0]  icode, ifun, len;
  logic        need_regids, need_valc;
  logic [63:0] valc, valp;

  always_comb begin
    for (int unsigned i = 0; i < 10; i++) b[i] = buf_q[head_q + PW'(i)];
    icode       = b[0][7:4];
    ifun        = b[0][3:0];
    need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    len         = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
    valc        = '0;
    if (need_valc) begin
      for (int unsigned k = 0; k < 8; k++) valc[8*k +: 8] = need_regids ? b[k+2] : b[k+1];
    end
    valp = head_pc_q + 64'(len);
  end

  logic have_instr, err_pkt, room, accept, rsp_take, pop;
  logic [CW-1:0] wr_n;

  always_comb begin
    have_instr = count_q >= CW'(len);
    // Once fetching has run past memory, an instruction that cannot complete becomes an error packet.
    err_pkt    = err_pending_q && !have_instr;
    out_valid  = !reset && !redirect_valid && !stopped_q && (have_instr || err_pkt);
    room       = ({1'b0, count_q} + (inflight_q ? CW1'(FETCH_BYTES) : '0) + CW1'(FETCH_BYTES))
                 <= CW1'(BUF_DEPTH);
    mem_req_valid = !reset && !redirect_valid && !stopped_q && !err_pending_q
                    && (fetch_addr_q < 64'(MEM_BYTES)) && room;
    mem_req_addr  = fetch_addr_q;
    accept     = mem_req_valid && mem_req_ready;
    rsp_take   = mem_rsp_valid && inflight_q && !redirect_valid;
    pop        = out_valid && out_ready;
    wr_n       = CW'(FETCH_BYTES) - CW'(skip_q);

    out_pc = '0; out_valP = '0; out_valC = '0; out_pred_pc = '0;
    out_icode = '0; out_ifun = '0; out_rA = '0; out_rB = '0;
    out_instr_valid = 1'b0; out_imem_error = 1'b0;
    if (err_pkt) begin
      out_pc          = head_pc_q;
      out_valP        = head_pc_q;
      out_pred_pc     = head_pc_q;
      out_icode       = 4'h1;
      out_rA          = 4'hF;
      out_rB          = 4'hF;
      out_instr_valid = 1'b1;
      out_imem_error  = 1'b1;
    end else if (count_q != '0) begin
      out_pc          = head_pc_q;
      out_valP        = valp;
      out_valC        = valc;
      out_pred_pc     = (icode == 4'h7 || icode == 4'h8) ? valc : valp;
      out_icode       = icode;
      out_ifun        = ifun;
      out_rA          = need_regids ? b[1][7:4] : 4'hF;
      out_rB          = need_regids ? b[1][3:0] : 4'hF;
      out_instr_valid = icode <= 4'hB;
    end
  end

  always_comb begin
    buf_d         = buf_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    head_pc_d     = head_pc_q;
    fetch_addr_d  = fetch_addr_q;
    skip_d        = skip_q;
    inflight_d    = inflight_q;
    stopped_d     = stopped_q;
    err_pending_d = err_pending_q;
    if (redirect_valid) begin
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      head_pc_d     = redirect_pc;
      fetch_addr_d  = redirect_pc & ALIGN_MASK;
      skip_d        = SW'(redirect_pc & OFS_MASK);
      inflight_d    = 1'b0;
      stopped_d     = 1'b0;
      err_pending_d = 1'b0;
    end else begin
      if (fetch_addr_q >= 64'(MEM_BYTES)) err_pending_d = 1'b1;
      if (rsp_take) inflight_d = 1'b0;
      if (accept) begin
        fetch_addr_d = fetch_addr_q + 64'(FETCH_BYTES);
        inflight_d   = 1'b1;
      end
      // Leading bytes below the redirect target are dropped from the first response.
      if (rsp_take) begin
        for (int unsigned j = 0; j < FETCH_BYTES; j++) begin
          if (SW'(j) >= skip_q) buf_d[tail_q + PW'(j) - PW'(skip_q)] = mem_rsp_data[8*j +: 8];
        end
        tail_d = tail_q + PW'(FETCH_BYTES) - PW'(skip_q);
        skip_d = '0;
      end
      if (pop && !err_pkt) begin
        head_d    = head_q + PW'(len);
        head_pc_d = valp;
      end
      if (pop && (err_pkt || icode == 4'h0)) stopped_d = 1'b1;
      count_d = count_q + (rsp_take ? wr_n : '0) - ((pop && !err_pkt) ? CW'(len) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      head_pc_q     <= RESET_PC;
      fetch_addr_q  <= RESET_PC & ALIGN_MASK;
      skip_q        <= SW'(RESET_PC & OFS_MASK);
      inflight_q    <= 1'b0;
      stopped_q     <= 1'b0;
      err_pending_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      head_pc_q     <= head_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      skip_q        <= skip_d;
      inflight_q    <= inflight_d;
      stopped_q     <= stopped_d;
      err_pending_q <= err_pending_d;
    end
  end

  always_ff @(posedge clk) buf_q <= buf_d;

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Bench for y86_fetch_queue: memory responder plus an ISA-level reference decoder that
// walks the expected instruction stream and checks every presented packet.
module tb_y86_fetch_queue;
  localparam int FB   = 4;
  localparam int MEMB = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_valP, out_valC, out_pred_pc;
  logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
  logic        out_instr_valid, out_imem_error;

  always #5 clk = ~clk;

  y86_fetch_queue #(.FETCH_BYTES(4), .BUF_DEPTH(16), .MEM_BYTES(2048), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_valP(out_valP), .out_valC(out_valC), .out_pred_pc(out_pred_pc),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
    .out_instr_valid(out_instr_valid), .out_imem_error(out_imem_error)
  );

  logic [7:0]  mem [0:MEMB-1];
  int          n_checks = 0, n_errors = 0, pkts = 0;
  logic        acc_pend;
  logic [63:0] acc_addr;
  logic [63:0] exp_pc;
  bit          model_stopped;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pred;
    logic        iv, err;
    int          len;
  } pkt_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int isa_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:         return 1;
      4'h2, 4'h6, 4'hA, 4'hB:   return 2;
      4'h3, 4'h4, 4'h5:         return 10;
      4'h7, 4'h8:               return 9;
      default:                  return 1;
    endcase
  endfunction

  function automatic pkt_t ref_decode(input logic [63:0] pc);
    pkt_t p;
    int   base;
    p.icode = 4'h0; p.ifun = 4'h0; p.ra = 4'hF; p.rb = 4'hF;
    p.valc = 64'd0; p.iv = 1'b1; p.err = 1'b0; p.len = 1;
    if (pc >= 64'(MEMB)) p.err = 1'b1;
    else begin
      base    = int'(pc);
      p.icode = mem[base][7:4];
      p.ifun  = mem[base][3:0];
      p.len   = isa_len(p.icode);
      p.iv    = (p.icode <= 4'hB);
      if (base + p.len > MEMB) p.err = 1'b1;
      else begin
        if (p.len == 2 || p.len == 10) begin
          p.ra = mem[base+1][7:4];
          p.rb = mem[base+1][3:0];
        end
        if (p.len >= 9)
          for (int k = 0; k < 8; k++) p.valc[8*k +: 8] = mem[base + p.len - 8 + k];
      end
    end
    if (p.err) begin
      p.icode = 4'h1; p.ifun = 4'h0; p.valp = pc; p.pred = pc;
    end else begin
      p.valp = pc + 64'(p.len);
      p.pred = (p.icode == 4'h7 || p.icode == 4'h8) ? p.valc : p.valp;
    end
    return p;
  endfunction

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < MEMB; i++) mem[i] = v;
  endtask

  task automatic settle();
    mem_rsp_valid = acc_pend;
    for (int j = 0; j < FB; j++) begin
      if (acc_pend && (acc_addr + 64'(j)) < 64'(MEMB)) mem_rsp_data[8*j +: 8] = mem[int'(acc_addr) + j];
      else mem_rsp_data[8*j +: 8] = 8'($urandom);
    end
    #1;
  endtask

  task automatic advance();
    pkt_t p;
    if (reset) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_req_valid", mem_req_valid, 0);
      exp_pc = 64'd0;
      model_stopped = 0;
    end else if (redirect_valid) begin
      chk("redir_out_valid", out_valid, 0);
      chk("redir_req_valid", mem_req_valid, 0);
      exp_pc = redirect_pc;
      model_stopped = 0;
    end else if (model_stopped) begin
      chk("stopped_quiet", out_valid, 0);
    end else if (out_valid) begin
      p = ref_decode(exp_pc);
      chk("pkt_pc", out_pc, exp_pc);
      chk("pkt_icode", out_icode, p.icode);
      chk("pkt_ifun", out_ifun, p.ifun);
      chk("pkt_valP", out_valP, p.valp);
      chk("pkt_imem_error", out_imem_error, p.err);
      if (!p.err) begin
        chk("pkt_rA", out_rA, p.ra);
        chk("pkt_rB", out_rB, p.rb);
        chk("pkt_valC", out_valC, p.valc);
        chk("pkt_pred_pc", out_pred_pc, p.pred);
        chk("pkt_instr_valid", out_instr_valid, p.iv);
      end
      if (out_ready) begin
        pkts++;
        if (p.err || p.icode == 4'h0) model_stopped = 1;
        else exp_pc = exp_pc + 64'(p.len);
      end
    end
    acc_pend = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    if (acc_pend) chk("req_aligned_in_range", {mem_req_addr[1:0], 1'b0, mem_req_addr < 64'(MEMB)}, 4'b0001);
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    settle();
    while (!out_valid && k < budget) begin
      advance();
      settle();
      k++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1;
    redirect_pc    = pc;
    step();
    redirect_valid = 0;
  endtask

  initial begin
    reset = 1; mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 1;
    acc_pend = 0; acc_addr = '0; exp_pc = '0; model_stopped = 0;

    // irmovq with a full 8-byte constant, then a nop
    fill_mem(8'h10);
    mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'hEF; mem[3] = 8'hCD; mem[4] = 8'hAB;
    mem[5] = 8'h89; mem[6] = 8'h67; mem[7] = 8'h45; mem[8] = 8'h23; mem[9] = 8'h01;
    @(negedge clk);
    step();
    settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_valP", out_valP, 0);
    chk("rst_out_icode", out_icode, 0);
    chk("rst_out_rA", out_rA, 0);
    advance();
    reset = 0;
    settle();
    chk("c0_req_valid", mem_req_valid, 1);
    chk("c0_req_addr", mem_req_addr, 0);
    chk("c0_out_valid", out_valid, 0);
    advance();
    settle(); chk("c1_req_addr", mem_req_addr, 4); chk("c1_out_valid", out_valid, 0); advance();
    settle(); chk("c2_req_addr", mem_req_addr, 8); chk("c2_out_valid", out_valid, 0); advance();
    settle(); chk("c3_out_valid", out_valid, 0); advance();
    settle();
    chk("c4_out_valid", out_valid, 1);
    chk("c4_icode", out_icode, 3);
    chk("c4_rA", out_rA, 4'hF);
    chk("c4_rB", out_rB, 0);
    chk("c4_valC", out_valC, 64'h0123456789ABCDEF);
    chk("c4_valP", out_valP, 10);
    advance();
    settle(); chk("c5_out_valid", out_valid, 1); chk("c5_pc", out_pc, 10); chk("c5_icode", out_icode, 1);
    advance();

    // back-pressure: buffer fills, requests stop, then drains one packet per cycle
    for (int i = 0; i < MEMB; i++) mem[i] = (i % 2 == 1) ? 8'h12 : 8'h20;
    do_reset();
    out_ready = 0;
    repeat (20) step();
    settle();
    chk("full_req_valid", mem_req_valid, 0);
    chk("full_out_valid", out_valid, 1);
    advance();
    out_ready = 1;
    for (int i = 0; i < 30; i++) begin
      settle();
      chk("stream_valid", out_valid, 1);
      advance();
    end
    settle(); chk("stream_pc", out_pc, 60); advance();

    // jmp prediction, then redirect to an unaligned target
    fill_mem(8'h10);
    mem[0] = 8'h70; mem[1] = 8'h40;
    for (int i = 2; i < 9; i++) mem[i] = 8'h00;
    mem[8'h41] = 8'h20; mem[8'h42] = 8'h34;
    do_reset();
    wait_valid(12, "jmp_wait");
    chk("jmp_icode", out_icode, 7);
    chk("jmp_pred", out_pred_pc, 64'h40);
    chk("jmp_valP", out_valP, 9);
    advance();
    do_redirect(64'h41);
    settle();
    chk("redir_req_valid_after", mem_req_valid, 1);
    chk("redir_req_addr", mem_req_addr, 64'h40);
    advance();
    wait_valid(10, "redir_wait");
    chk("redir_pc", out_pc, 64'h41);
    chk("redir_icode", out_icode, 2);
    chk("redir_rA", out_rA, 3);
    chk("redir_rB", out_rB, 4);
    advance();

    // redirect coinciding with a returning response
    fill_mem(8'h10);
    mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'hAA; mem[3] = 8'hBB;
    mem[12'h100] = 8'h00; mem[12'h101] = 8'h00; mem[12'h102] = 8'h60; mem[12'h103] = 8'h23;
    do_reset();
    step();
    do_redirect(64'h102);
    wait_valid(10, "drop_wait");
    chk("drop_pc", out_pc, 64'h102);
    chk("drop_icode", out_icode, 6);
    chk("drop_rA", out_rA, 2);
    chk("drop_rB", out_rB, 3);
    advance();

    // instruction running past the end of instruction memory
    fill_mem(8'h10);
    mem[MEMB-1] = 8'h20;
    do_redirect(64'h7FF);
    wait_valid(12, "err_wait");
    chk("err_flag", out_imem_error, 1);
    chk("err_icode", out_icode, 1);
    chk("err_ifun", out_ifun, 0);
    chk("err_pc", out_pc, 64'h7FF);
    chk("err_valP", out_valP, 64'h7FF);
    advance();
    repeat (8) begin
      settle(); chk("err_quiet", out_valid, 0); advance();
    end

    // halt stops the stream; invalid icode is a 1-byte instruction
    mem[12'h200] = 8'h00;
    mem[12'h300] = 8'hC0;
    do_redirect(64'h200);
    wait_valid(10, "halt_wait");
    chk("halt_icode", out_icode, 0);
    chk("halt_pc", out_pc, 64'h200);
    chk("halt_valP", out_valP, 64'h201);
    advance();
    repeat (8) begin
      settle(); chk("halt_quiet", out_valid, 0); advance();
    end
    do_redirect(64'h300);
    wait_valid(10, "inv_wait");
    chk("inv_icode", out_icode, 4'hC);
    chk("inv_instr_valid", out_instr_valid, 0);
    chk("inv_valP", out_valP, 64'h301);
    chk("inv_pred", out_pred_pc, 64'h301);
    advance();
    wait_valid(10, "inv_next_wait");
    chk("inv_next_pc", out_pc, 64'h301);
    advance();

    // random program, random handshakes, redirects and occasional resets
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    pkts = 0;
    do_redirect(64'($urandom_range(0, MEMB - 1)));
    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      reset          = ($urandom_range(0, 499) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'(MEMB - 12 + int'($urandom_range(0, 14)));
      else redirect_pc = 64'($urandom_range(0, MEMB - 1));
      step();
    end
    reset = 0; redirect_valid = 0;
    chk("random_progress", (pkts > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
